// File: rtl/store_commit_buffer_if.sv
// Bundle between the store queue / dcache and the store commit buffer.
// The store queue side (master) drives retired stores and the dcache ack; the buffer (slave) drives the rest.
interface store_commit_buffer_if #(
    parameter int N_WAY    = 2,
    parameter int WB_DEPTH = 4,
    parameter int XLEN     = 32,
    parameter int POS_W    = 3
);
    localparam int CNT_W = $clog2(WB_DEPTH) + 1;

    // Retire lanes, lane 0 oldest. Size: 0 = BYTE, 1 = HALF, 2 = WORD.
    logic [N_WAY-1:0]            ret_valid_i;
    logic [N_WAY-1:0][XLEN-1:0]  ret_addr_i;
    logic [N_WAY-1:0][XLEN-1:0]  ret_data_i;
    logic [N_WAY-1:0][1:0]       ret_size_i;
    logic [N_WAY-1:0][POS_W-1:0] ret_pos_i;

    logic [CNT_W-1:0]            wb_free_slots_o;
    logic                        wb_empty_o;
    logic                        wb_overflow_o;

    logic                        dc_wr_req_o;
    logic [XLEN-1:0]             dc_wr_addr_o;
    logic [XLEN-1:0]             dc_wr_data_o;
    logic [3:0]                  dc_wr_be_o;
    logic                        dc_wr_ack_i;

    logic                        done_valid_o;
    logic [POS_W-1:0]            done_pos_o;
    logic [XLEN-1:0]             done_addr_o;
    logic [XLEN-1:0]             done_data_o;
    logic [1:0]                  done_size_o;

    modport master (
        output ret_valid_i, ret_addr_i, ret_data_i, ret_size_i, ret_pos_i, dc_wr_ack_i,
        input  wb_free_slots_o, wb_empty_o, wb_overflow_o,
        input  dc_wr_req_o, dc_wr_addr_o, dc_wr_data_o, dc_wr_be_o,
        input  done_valid_o, done_pos_o, done_addr_o, done_data_o, done_size_o
    );

    modport slave (
        input  ret_valid_i, ret_addr_i, ret_data_i, ret_size_i, ret_pos_i, dc_wr_ack_i,
        output wb_free_slots_o, wb_empty_o, wb_overflow_o,
        output dc_wr_req_o, dc_wr_addr_o, dc_wr_data_o, dc_wr_be_o,
        output done_valid_o, done_pos_o, done_addr_o, done_data_o, done_size_o
    );
endinterface

// File: rtl/store_commit_buffer.sv
// Program-ordered write buffer for retired stores: accepts up to N_WAY stores per cycle,
// drains one at a time through a req/ack dcache port and reports each completion.
module store_commit_buffer #(
    parameter int N_WAY    = 2,
    parameter int WB_DEPTH = 4,
    parameter int XLEN     = 32,
    parameter int POS_W    = 3
) (
    input  logic clk,
    input  logic rst_n,
    store_commit_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;

    logic [XLEN-1:0]   mem_addr_q [WB_DEPTH];
    logic [XLEN-1:0]   mem_data_q [WB_DEPTH];
    logic [1:0]        mem_size_q [WB_DEPTH];
    logic [POS_W-1:0]  mem_pos_q  [WB_DEPTH];

    logic [CNT_W-1:0]  free_s, enq_cnt_s;
    logic [N_WAY-1:0]  lane_acc_s;
    logic [PTR_W-1:0]  lane_slot_s [N_WAY];
    logic              drop_s, pop_s;
    logic [XLEN-1:0]   head_addr_s;

    function automatic logic [3:0] be_f(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    be_f = 4'b0001 << off;
            2'd1:    be_f = 4'b0011 << {off[1], 1'b0};
            2'd2:    be_f = 4'b1111;
            default: be_f = 4'b0000;
        endcase
    endfunction

    assign free_s      = CNT_W'(WB_DEPTH) - count_q;
    assign head_addr_s = mem_addr_q[head_q];

    // Compact valid lanes onto consecutive slots from tail; lanes beyond free space are dropped.
    always_comb begin
        logic [CNT_W-1:0] off_v;
        off_v      = '0;
        drop_s     = 1'b0;
        lane_acc_s = '0;
        for (int l = 0; l < N_WAY; l++) begin
            lane_slot_s[l] = tail_q + off_v[PTR_W-1:0];
            if (bus.ret_valid_i[l]) begin
                if (off_v < free_s) begin
                    lane_acc_s[l] = 1'b1;
                    off_v         = off_v + CNT_W'(1);
                end else begin
                    drop_s = 1'b1;
                end
            end else begin
                lane_acc_s[l] = 1'b0;
            end
        end
        enq_cnt_s = off_v;
    end

    // Next-state for the drain FSM and the buffer bookkeeping.
    always_comb begin
        state_d = state_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((count_q + enq_cnt_s) != CNT_W'(0)) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.dc_wr_ack_i) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DONE: begin
                pop_s = 1'b1;
                // Same-cycle enqueues keep the port busy without an idle bubble.
                if ((count_q + enq_cnt_s - CNT_W'(1)) != CNT_W'(0)) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        count_d    = count_q + enq_cnt_s - CNT_W'(pop_s);
        head_d     = head_q + PTR_W'(pop_s);
        tail_d     = tail_q + enq_cnt_s[PTR_W-1:0];
        overflow_d = overflow_q | drop_s;
    end

    // Control state and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage, written at the compacted slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WB_DEPTH; i++) begin
                mem_addr_q[i] <= '0;
                mem_data_q[i] <= '0;
                mem_size_q[i] <= '0;
                mem_pos_q[i]  <= '0;
            end
        end else begin
            for (int l = 0; l < N_WAY; l++) begin
                if (lane_acc_s[l]) begin
                    mem_addr_q[lane_slot_s[l]] <= bus.ret_addr_i[l];
                    mem_data_q[lane_slot_s[l]] <= bus.ret_data_i[l];
                    mem_size_q[lane_slot_s[l]] <= bus.ret_size_i[l];
                    mem_pos_q[lane_slot_s[l]]  <= bus.ret_pos_i[l];
                end
            end
        end
    end

    // Outputs decode from registered state only, so reset clears them immediately.
    always_comb begin
        bus.dc_wr_req_o  = 1'b0;
        bus.dc_wr_addr_o = '0;
        bus.dc_wr_data_o = '0;
        bus.dc_wr_be_o   = 4'b0000;
        bus.done_valid_o = 1'b0;
        bus.done_pos_o   = '0;
        bus.done_addr_o  = '0;
        bus.done_data_o  = '0;
        bus.done_size_o  = 2'd0;
        if (state_q == ST_REQ) begin
            bus.dc_wr_req_o  = 1'b1;
            bus.dc_wr_addr_o = {head_addr_s[XLEN-1:2], 2'b00};
            bus.dc_wr_data_o = mem_data_q[head_q] << {head_addr_s[1:0], 3'b000};
            bus.dc_wr_be_o   = be_f(mem_size_q[head_q], head_addr_s[1:0]);
        end else if (state_q == ST_DONE) begin
            bus.done_valid_o = 1'b1;
            bus.done_pos_o   = mem_pos_q[head_q];
            bus.done_addr_o  = head_addr_s;
            bus.done_data_o  = mem_data_q[head_q];
            bus.done_size_o  = mem_size_q[head_q];
        end else begin
            bus.dc_wr_req_o  = 1'b0;
        end
    end

    assign bus.wb_free_slots_o = free_s;
    assign bus.wb_empty_o      = (count_q == CNT_W'(0)) && (state_q == ST_IDLE);
    assign bus.wb_overflow_o   = overflow_q;

endmodule
